// File: rtl/inference_sequencer.sv
// Per-sample control for a layered ANN: fetch one input row, run each layer in turn,
// then score the prediction against the label. Outputs are decoded from the state register.
module inference_sequencer #(
  parameter int layers      = 2,
  parameter int output_rows = 10,
  parameter int max_inputs  = 200,
  localparam int LB = $clog2(output_rows),
  localparam int NB = $clog2(max_inputs + 1),
  localparam int LS = (layers > 1) ? $clog2(layers) : 1
) (
  input  logic          clk,
  input  logic          rst_overall,
  input  logic          enable_inference,
  input  logic          upload_done,
  input  logic [NB-1:0] num_samples,
  input  logic          input_loaded,
  input  logic [LB-1:0] label,
  input  logic          layer_done,
  input  logic [LB-1:0] predicted,
  output logic          load_req,
  output logic          layer_start,
  output logic [LS-1:0] layer_sel,
  output logic          busy,
  output logic [NB-1:0] sample_idx,
  output logic [NB-1:0] correct_count,
  output logic          all_done,
  output logic [2:0]    state_dbg
);

  // Handshakes: every input and output strobe is a single-cycle pulse sampled at the
  // rising edge; the loader and layer engine are only listened to in the state waiting on them.

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] WAIT_LOAD = 3'd2;
  localparam logic [2:0] START_L   = 3'd3;
  localparam logic [2:0] RUN_L     = 3'd4;
  localparam logic [2:0] CHECK     = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;

  localparam logic [LS-1:0] LAST_LAYER = LS'(layers - 1);

  logic [2:0]    state;
  logic [NB-1:0] num_q;
  logic [LB-1:0] label_q;
  logic [LB-1:0] predicted_q;
  logic [NB-1:0] idx_next;

  assign idx_next = sample_idx + NB'(1);

  always_ff @(posedge clk) begin
    if (rst_overall) begin
      state         <= IDLE;
      num_q         <= '0;
      label_q       <= '0;
      predicted_q   <= '0;
      layer_sel     <= '0;
      sample_idx    <= '0;
      correct_count <= '0;
    end else if (state != IDLE && !enable_inference) begin
      // Abort: drop straight back to idle, leaving the counters as they were.
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (enable_inference && upload_done) begin
            num_q         <= num_samples;
            sample_idx    <= '0;
            correct_count <= '0;
            layer_sel     <= '0;
            state         <= (num_samples != '0) ? LOAD : DONE;
          end
        end
        LOAD: state <= WAIT_LOAD;
        WAIT_LOAD: begin
          if (input_loaded) begin
            label_q   <= label;
            layer_sel <= '0;
            state     <= START_L;
          end
        end
        START_L: state <= RUN_L;
        RUN_L: begin
          if (layer_done) begin
            if (layer_sel == LAST_LAYER) begin
              predicted_q <= predicted;
              state       <= CHECK;
            end else begin
              layer_sel <= layer_sel + LS'(1);
              state     <= START_L;
            end
          end
        end
        CHECK: begin
          // The bound check keeps the counters saturated at num_q.
          if (sample_idx < num_q) begin
            sample_idx <= idx_next;
            if (predicted_q == label_q) correct_count <= correct_count + NB'(1);
          end
          state <= (idx_next >= num_q) ? DONE : LOAD;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_req    = (state == LOAD);
  assign layer_start = (state == START_L);
  assign all_done    = (state == DONE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

endmodule
